// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter sharing one packed dual-lane 4-bit
// add/sub unit among NREQ requesters, with a tagged response channel.
//
// Ports:
//   clk, rst           clock (rising edge), async active-low reset
//   req_valid/ready    per-requester handshake (ready is one-hot)
//   req_in1/in2/op     packed per-requester operands and opcode
//   au_in1/in2/op      operands to the shared unit, held during WAIT
//   au_start/done/out  unit launch pulse, completion strobe, result
//   resp_*             response: owner id, data, timeout error flag
//   busy               high whenever an operation is in progress
module addsub_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_in1,
    input  logic [8*NREQ-1:0] req_in2,
    input  logic [2*NREQ-1:0] req_op,
    output logic [7:0]        au_in1,
    output logic [7:0]        au_in2,
    output logic [1:0]        au_op,
    output logic              au_start,
    input  logic              au_done,
    input  logic [7:0]        au_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_data,
    output logic              resp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] win;
    logic           found;
    logic [7:0]     cnt;
    logic [7:0]     sel_in1;
    logic [7:0]     sel_in2;
    logic [1:0]     sel_op;
    logic [7:0]     hold_in1;
    logic [7:0]     hold_in2;
    logic [1:0]     hold_op;
    logic [7:0]     rdata;
    logic           rerr;
    logic           gnt_valid;
    logic           timeout_hit;

    // Winner = lowest requesting index at or above ptr; if none, the
    // lowest requesting index overall (the wrapped part of the search).
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= ptr)) begin
                win = IDW'(i);
            end
        end
    end

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        sel_op  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_in1 = req_in1[8*i +: 8];
                sel_in2 = req_in2[8*i +: 8];
                sel_op  = req_op[2*i +: 2];
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                gnt_valid    = req_valid[i];
                req_ready[i] = (state == GRANT);
            end
        end
    end

    // The cycle that would be WAIT cycle number TIMEOUT is the last one.
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = GRANT;
            GRANT:   state_nx = gnt_valid ? WAIT : IDLE;
            WAIT:    if (au_done || timeout_hit) state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are captured at arbitration time; the requester must hold
    // them until accepted, so they are still current in GRANT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            cnt      <= '0;
            hold_in1 <= '0;
            hold_in2 <= '0;
            hold_op  <= '0;
            rdata    <= '0;
            rerr     <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= win;
                        hold_in1 <= sel_in1;
                        hold_in2 <= sel_in2;
                        hold_op  <= sel_op;
                    end
                end
                GRANT: begin
                    cnt <= '0;
                    if (gnt_valid) begin
                        ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (au_done) begin
                        rdata <= au_out;
                        rerr  <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        rerr  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign au_in1     = hold_in1;
    assign au_in2     = hold_in2;
    assign au_op      = hold_op;
    assign au_start   = (state == GRANT) && gnt_valid;
    assign resp_valid = (state == RESP);
    assign resp_id    = gnt;
    assign resp_data  = rdata;
    assign resp_err   = rerr;
    assign busy       = (state != IDLE);

endmodule
